// File: rtl/ttl_pkg.sv
// Shared FSM state encoding for the chip-select arbiter.
package ttl_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } cs_state_t;
endpackage

// File: rtl/chip_select_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above PTR, wrapping to 0.
module rr_pick #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     REQ,
    input  logic [SEL_WIDTH-1:0] PTR,
    output logic [SEL_WIDTH-1:0] winner,
    output logic                 any
);

    function automatic int wrap_idx(input logic [SEL_WIDTH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= WIDTH) s = s - WIDTH;
        return s;
    endfunction

    // Scan from the farthest offset down so the nearest request to PTR is written last.
    always_comb begin
        winner = '0;
        any    = |REQ;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (REQ[wrap_idx(PTR, i)]) winner = SEL_WIDTH'(wrap_idx(PTR, i));
        end
    end

endmodule

// File: rtl/chip_select_arbiter.sv
// Round-robin chip-select arbiter driving a '138-style decoder (A, G1, G2A, G2B)
// through IDLE -> SETUP -> ACTIVE -> RECOVER with a bounded hold time.
module chip_select_arbiter
    import ttl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_HOLD  = 16,
    localparam int SEL_WIDTH = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 CLR_n,
    input  logic                 EN,
    input  logic [WIDTH-1:0]     REQ,
    output logic [SEL_WIDTH-1:0] A,
    output logic                 G1,
    output logic                 G2A,
    output logic                 G2B,
    output logic                 GNT_VALID,
    output logic                 TOUT,
    output cs_state_t            DBG_STATE
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    cs_state_t            state_q;
    logic [SEL_WIDTH-1:0] a_q;
    logic [SEL_WIDTH-1:0] ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 g1_q, g2a_q, g2b_q, gv_q, tout_q;

    logic [SEL_WIDTH-1:0] winner;
    logic                 any_req;
    logic                 req_drop;
    logic                 hold_done;
    logic [SEL_WIDTH-1:0] ptr_next;

    rr_pick #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_pick (
        .REQ    (REQ),
        .PTR    (ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    assign req_drop  = !REQ[a_q];
    assign hold_done = (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign ptr_next  = (a_q == SEL_WIDTH'(WIDTH - 1)) ? '0 : a_q + SEL_WIDTH'(1);

    // A only moves on the IDLE/RECOVER -> SETUP edge, when the decoder is already disabled.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            g1_q    <= 1'b0;
            g2a_q   <= 1'b1;
            g2b_q   <= 1'b1;
            gv_q    <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            case (state_q)
                IDLE, RECOVER: begin
                    if (EN && any_req) begin
                        a_q     <= winner;
                        state_q <= SETUP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SETUP: begin
                    state_q <= ACTIVE;
                    cnt_q   <= '0;
                    g1_q    <= 1'b1;
                    g2a_q   <= 1'b0;
                    g2b_q   <= 1'b0;
                    gv_q    <= 1'b1;
                end
                ACTIVE: begin
                    if (req_drop || hold_done) begin
                        state_q <= RECOVER;
                        ptr_q   <= ptr_next;
                        g1_q    <= 1'b0;
                        g2a_q   <= 1'b1;
                        g2b_q   <= 1'b1;
                        gv_q    <= 1'b0;
                        // A release coinciding with expiry is not a timeout.
                        tout_q  <= hold_done && !req_drop;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign A         = a_q;
    assign G1        = g1_q;
    assign G2A       = g2a_q;
    assign G2B       = g2b_q;
    assign GNT_VALID = gv_q;
    assign TOUT      = tout_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_chip_select_arbiter.sv
// Directed bench for chip_select_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_chip_select_arbiter;
    import ttl_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR_n;
    logic       EN, en4;
    logic [7:0] REQ, req4;
    logic [2:0] A, a4;
    logic       G1, G2A, G2B, GNT_VALID, TOUT;
    logic       g1_4, g2a_4, g2b_4, gv_4, tout_4;
    cs_state_t  st, st4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic       en;
        logic [7:0] req;
        cs_state_t  st;
        logic [2:0] a;
        logic       g;
        logic       t;
    } vec_t;

    vec_t tbl[28];

    always #5 CLK = ~CLK;

    chip_select_arbiter #(.WIDTH(8), .MAX_HOLD(16)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .EN(EN), .REQ(REQ),
        .A(A), .G1(G1), .G2A(G2A), .G2B(G2B),
        .GNT_VALID(GNT_VALID), .TOUT(TOUT), .DBG_STATE(st)
    );

    chip_select_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut4 (
        .CLK(CLK), .CLR_n(CLR_n), .EN(en4), .REQ(req4),
        .A(a4), .G1(g1_4), .G2A(g2a_4), .G2B(g2b_4),
        .GNT_VALID(gv_4), .TOUT(tout_4), .DBG_STATE(st4)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Packed view: {state, A, G1, G2A, G2B, GNT_VALID, TOUT}
    task automatic chk(input string nm, input cs_state_t es, input logic [2:0] ea,
                       input logic eg, input logic et);
        logic [9:0] act, exp;
        act = {st, A, G1, G2A, G2B, GNT_VALID, TOUT};
        exp = {es, ea, eg, !eg, !eg, eg, et};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st/A/G1/G2A/G2B/GV/TOUT=%b required %b", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input cs_state_t es, input logic [2:0] ea,
                        input logic eg, input logic et);
        logic [9:0] act, exp;
        act = {st4, a4, g1_4, g2a_4, g2b_4, gv_4, tout_4};
        exp = {es, ea, eg, !eg, !eg, eg, et};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st/A/G1/G2A/G2B/GV/TOUT=%b required %b", nm, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h08, SETUP,   3'd3, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h08, ACTIVE,  3'd3, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'h08, ACTIVE,  3'd3, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'h08, ACTIVE,  3'd3, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'h08, ACTIVE,  3'd3, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'h00, RECOVER, 3'd3, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, IDLE,    3'd3, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h19, SETUP,   3'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h19, ACTIVE,  3'd4, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h08, RECOVER, 3'd4, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h08, IDLE,    3'd4, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h02, IDLE,    3'd4, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h02, IDLE,    3'd4, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 8'h02, SETUP,   3'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'h02, ACTIVE,  3'd1, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 8'h02, ACTIVE,  3'd1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 8'h00, RECOVER, 3'd1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 8'h02, IDLE,    3'd1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 8'h40, SETUP,   3'd6, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 8'h40, ACTIVE,  3'd6, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 8'h00, RECOVER, 3'd6, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 8'h81, SETUP,   3'd7, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 8'h81, ACTIVE,  3'd7, 1'b1, 1'b0};
        tbl[23] = '{1'b1, 8'h01, RECOVER, 3'd7, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 8'h01, SETUP,   3'd0, 1'b0, 1'b0};
        tbl[25] = '{1'b1, 8'h01, ACTIVE,  3'd0, 1'b1, 1'b0};
        tbl[26] = '{1'b1, 8'h00, RECOVER, 3'd0, 1'b0, 1'b0};
        tbl[27] = '{1'b1, 8'h00, IDLE,    3'd0, 1'b0, 1'b0};

        // clock/reset
        CLR_n = 1'b0; EN = 1'b0; REQ = 8'h00; en4 = 1'b0; req4 = 8'h00;
        #12;
        chk("reset_state", IDLE, 3'd0, 1'b0, 1'b0);
        chk4("reset_state_mh4", IDLE, 3'd0, 1'b0, 1'b0);
        @(negedge CLK);
        CLR_n = 1'b1;
        tick();

        // MAX_HOLD=4: pure expiry, then release coinciding with expiry
        en4 = 1'b1; req4 = 8'h04;
        tick(); chk4("mh4_setup", SETUP, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk4("mh4_active", ACTIVE, 3'd2, 1'b1, 1'b0);
        end
        tick(); chk4("mh4_expiry_tout", RECOVER, 3'd2, 1'b0, 1'b1);
        tick(); chk4("mh4_regrant", SETUP, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk4("mh4_active2", ACTIVE, 3'd2, 1'b1, 1'b0);
        end
        req4 = 8'h00;
        tick(); chk4("mh4_simul_no_tout", RECOVER, 3'd2, 1'b0, 1'b0);
        tick(); chk4("mh4_idle", IDLE, 3'd2, 1'b0, 1'b0);
        en4 = 1'b0;

        // vector table on the default instance
        for (int i = 0; i < 28; i++) begin
            EN = tbl[i].en; REQ = tbl[i].req;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].a, tbl[i].g, tbl[i].t);
        end

        // fresh reset, then all requesters held: grant order 0..7,0
        EN = 1'b0; REQ = 8'h00;
        #2 CLR_n = 1'b0;
        #2 CLR_n = 1'b1;
        tick();
        for (int g = 0; g < 8; g++) exp_q.push_back(3'(g));
        exp_q.push_back(3'd0);
        EN = 1'b1; REQ = 8'hFF;
        while (exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            tick(); chk($sformatf("fair_setup_%0d", e), SETUP, e, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                tick(); chk($sformatf("fair_active_%0d_c%0d", e, c), ACTIVE, e, 1'b1, 1'b0);
            end
            tick(); chk($sformatf("fair_recover_tout_%0d", e), RECOVER, e, 1'b0, 1'b1);
        end

        // async reset mid-ACTIVE
        tick(); chk("pre_reset_setup", SETUP, 3'd1, 1'b0, 1'b0);
        tick(); chk("pre_reset_active", ACTIVE, 3'd1, 1'b1, 1'b0);
        #3 CLR_n = 1'b0;
        #1 chk("async_reset_mid_active", IDLE, 3'd0, 1'b0, 1'b0);
        #2 CLR_n = 1'b1;
        REQ = 8'h81;
        tick(); chk("post_reset_ptr0", SETUP, 3'd0, 1'b0, 1'b0);
        tick(); chk("post_reset_active", ACTIVE, 3'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
